// File: rtl/row_mapper_stream.sv
// Registered stride-configurable row-to-PE fan-out with valid/ready on both sides.
// Optional beat counter port beat_cnt is built when ROW_MAPPER_STATS_EN is defined.
module row_mapper_stream #(
    parameter int PE_ROWS    = 5,
    parameter int PE_COLS    = 5,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_STRIDE = 2,
    localparam int NUM_IN    = (PE_ROWS - 1) * MAX_STRIDE + PE_COLS,
    localparam int SW        = $clog2(MAX_STRIDE + 1),
    localparam int NUM_PE    = PE_ROWS * PE_COLS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_valid,
    input  logic [SW-1:0]                cfg_stride,
    output logic                         cfg_ready,
    output logic                         cfg_err,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_rows,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_PE*DATA_WIDTH-1:0] out_pe,
    output logic [SW-1:0]                out_stride
`ifdef ROW_MAPPER_STATS_EN
    ,
    output logic [31:0]                  beat_cnt
`endif
);

    localparam logic [SW-1:0] STRIDE_ONE = SW'(1);
    localparam logic [SW-1:0] STRIDE_MAX = SW'(MAX_STRIDE);

    logic [SW-1:0]                r_stride;
    logic                         r_cfg_err;
    logic                         r_out_valid;
    logic [NUM_PE*DATA_WIDTH-1:0] r_out_pe;
    logic [SW-1:0]                r_out_stride;

    logic                         w_in_ready;
    logic                         w_cfg_ready;
    logic                         w_accept;
    logic                         w_drain;
    logic                         w_cfg_accept;
    logic                         w_cfg_legal;
    logic [NUM_PE*DATA_WIDTH-1:0] w_mapped;

    // Config only enters an empty pipeline, so each beat keeps the stride it was taken with.
    assign w_cfg_ready  = !r_out_valid;
    assign w_in_ready   = (!r_out_valid || out_ready) && !cfg_valid;
    assign w_accept     = in_valid && w_in_ready;
    assign w_drain      = r_out_valid && out_ready;
    assign w_cfg_accept = cfg_valid && w_cfg_ready;
    assign w_cfg_legal  = (cfg_stride != '0) && (cfg_stride <= STRIDE_MAX);

    // Every lane precomputes its source row for each legal stride; the live stride picks one.
    genvar gi, gs;
    generate
        for (gi = 0; gi < NUM_PE; gi++) begin : g_lane
            localparam int R = gi / PE_COLS;
            localparam int C = gi % PE_COLS;
            logic [DATA_WIDTH-1:0] w_cand [MAX_STRIDE];
            logic [DATA_WIDTH-1:0] w_lane;

            for (gs = 0; gs < MAX_STRIDE; gs++) begin : g_cand
                assign w_cand[gs] = in_rows[(R * (gs + 1) + C) * DATA_WIDTH +: DATA_WIDTH];
            end

            always_comb begin
                w_lane = w_cand[0];
                for (int s = 1; s < MAX_STRIDE; s++) begin
                    if (r_stride == SW'(s + 1)) begin
                        w_lane = w_cand[s];
                    end
                end
            end

            assign w_mapped[gi*DATA_WIDTH +: DATA_WIDTH] = w_lane;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_pe     <= '0;
            r_out_stride <= STRIDE_ONE;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_pe     <= w_mapped;
            r_out_stride <= r_stride;
        end else if (w_drain) begin
            r_out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stride  <= STRIDE_ONE;
            r_cfg_err <= 1'b0;
        end else if (w_cfg_accept) begin
            if (w_cfg_legal) begin
                r_stride  <= cfg_stride;
                r_cfg_err <= 1'b0;
            end else begin
                r_cfg_err <= 1'b1;
            end
        end
    end

`ifdef ROW_MAPPER_STATS_EN
    logic [31:0] r_beat_cnt;

    // Any accepted config starts a fresh count, even an illegal one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
        end else if (w_cfg_accept) begin
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 32'd1;
        end
    end

    assign beat_cnt = r_beat_cnt;
`endif

    assign cfg_ready  = w_cfg_ready;
    assign cfg_err    = r_cfg_err;
    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_pe     = r_out_pe;
    assign out_stride = r_out_stride;

endmodule

// File: tb/tb_row_mapper_stream.sv
// Scoreboard bench for row_mapper_stream: beats are queued on accept and compared on drain.
module tb_row_mapper_stream;

    localparam int PE_ROWS = 5;
    localparam int PE_COLS = 5;
    localparam int DW      = 16;
    localparam int MAXS    = 2;
    localparam int NUM_IN  = (PE_ROWS - 1) * MAXS + PE_COLS;
    localparam int SW      = $clog2(MAXS + 1);
    localparam int NUM_PE  = PE_ROWS * PE_COLS;
    localparam int PE_W    = NUM_PE * DW;

    typedef struct packed {
        logic [PE_W-1:0] pe;
        logic [SW-1:0]   stride;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 cfg_valid;
    logic [SW-1:0]        cfg_stride;
    logic                 cfg_ready;
    logic                 cfg_err;
    logic                 in_valid;
    logic                 in_ready;
    logic [NUM_IN*DW-1:0] in_rows;
    logic                 out_valid;
    logic                 out_ready;
    logic [PE_W-1:0]      out_pe;
    logic [SW-1:0]        out_stride;
`ifdef ROW_MAPPER_STATS_EN
    logic [31:0]          beat_cnt;
`endif

    int    n_vec  = 0;
    int    n_err  = 0;
    int    n_pops = 0;
    int    m_stride = 1;
    int    m_beats  = 0;
    beat_t sb [$];

    row_mapper_stream dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_stride (cfg_stride),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rows    (in_rows),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pe     (out_pe),
        .out_stride (out_stride)
`ifdef ROW_MAPPER_STATS_EN
        ,
        .beat_cnt   (beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [NUM_IN*DW-1:0] build_rows(input logic [DW-1:0] base);
        logic [NUM_IN*DW-1:0] rows;
        for (int i = 0; i < NUM_IN; i++) rows[i*DW +: DW] = base + DW'(i);
        return rows;
    endfunction

    function automatic logic [PE_W-1:0] map_rows(input logic [NUM_IN*DW-1:0] rows, input int s);
        logic [PE_W-1:0] res;
        for (int r = 0; r < PE_ROWS; r++)
            for (int c = 0; c < PE_COLS; c++)
                res[(r*PE_COLS + c)*DW +: DW] = rows[(r*s + c)*DW +: DW];
        return res;
    endfunction

    function automatic logic [DW-1:0] lane(input int r, input int c);
        return out_pe[(r*PE_COLS + c)*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop/compare on drain, push the model's expectation on accept.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_underflow: got beat stride=%0d, required no beat", out_stride);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    n_pops++;
                    if (out_pe !== e.pe || out_stride !== e.stride) begin
                        n_err++;
                        $display("FAIL sb_beat: got stride=%0d pe=%h, required stride=%0d pe=%h",
                                 out_stride, out_pe, e.stride, e.pe);
                    end
                end
            end
            if (cfg_valid && cfg_ready) begin
                if (cfg_stride >= 1 && int'(cfg_stride) <= MAXS) m_stride = int'(cfg_stride);
                m_beats = 0;
            end
            if (in_valid && in_ready) begin
                sb.push_back('{pe: map_rows(in_rows, m_stride), stride: SW'(m_stride)});
                m_beats++;
            end
        end
    end

    task automatic do_cfg(input int s);
        cfg_valid  = 1'b1;
        cfg_stride = SW'(s);
        tick();
        cfg_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_stride = '0; in_valid = 1'b0;
        out_ready = 1'b1; in_rows = build_rows(16'h100);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        n_vec++; if (out_pe !== '0) begin n_err++; $display("FAIL rst_out_pe: got %h required 0", out_pe); end
        n_vec++; if (out_stride !== SW'(1)) begin n_err++; $display("FAIL rst_out_stride: got %0d required 1", out_stride); end
        n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL rst_cfg_err: got %b required 0", cfg_err); end
        n_vec++; if (cfg_ready !== 1'b1 || in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got cfg_ready=%b in_ready=%b required 1/1", cfg_ready, in_ready); end
`ifdef ROW_MAPPER_STATS_EN
        n_vec++; if (beat_cnt !== 32'd0) begin n_err++; $display("FAIL rst_beat_cnt: got %0d required 0", beat_cnt); end
`endif
    endtask

    task automatic test_default_stride();
        in_rows = build_rows(16'h100); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || out_stride !== SW'(1)) begin n_err++; $display("FAIL s1_valid_stride: got valid=%b stride=%0d required 1/1", out_valid, out_stride); end
        n_vec++; if (lane(0,0) !== 16'h100) begin n_err++; $display("FAIL s1_lane00: got %h required 0100", lane(0,0)); end
        n_vec++; if (lane(2,3) !== 16'h105) begin n_err++; $display("FAIL s1_lane23: got %h required 0105", lane(2,3)); end
        n_vec++; if (lane(4,4) !== 16'h108) begin n_err++; $display("FAIL s1_lane44: got %h required 0108", lane(4,4)); end
        tick();
    endtask

    task automatic test_stride2();
        cfg_valid = 1'b1; cfg_stride = SW'(2); in_valid = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL cfg_blocks_data: got in_ready=%b required 0", in_ready); end
        tick();
        cfg_valid = 1'b0; in_valid = 1'b0;
        n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL s2_cfg_err: got %b required 0", cfg_err); end
`ifdef ROW_MAPPER_STATS_EN
        n_vec++; if (beat_cnt !== 32'd0) begin n_err++; $display("FAIL cfg_clears_cnt: got %0d required 0", beat_cnt); end
`endif
        in_rows = build_rows(16'h100); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_stride !== SW'(2)) begin n_err++; $display("FAIL s2_stride: got %0d required 2", out_stride); end
        n_vec++; if (lane(1,0) !== 16'h102) begin n_err++; $display("FAIL s2_lane10: got %h required 0102", lane(1,0)); end
        n_vec++; if (lane(4,0) !== 16'h108) begin n_err++; $display("FAIL s2_lane40: got %h required 0108", lane(4,0)); end
        n_vec++; if (lane(4,4) !== 16'h10C) begin n_err++; $display("FAIL s2_lane44: got %h required 010c", lane(4,4)); end
        tick();
    endtask

    task automatic test_illegal_cfg();
        do_cfg(0);
        n_vec++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL bad_cfg0_err: got %b required 1", cfg_err); end
        do_cfg(3);
        n_vec++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL bad_cfg3_err: got %b required 1", cfg_err); end
        in_rows = build_rows(16'h100); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_vec++; if (lane(4,4) !== 16'h10C || out_stride !== SW'(2)) begin n_err++; $display("FAIL bad_cfg_keeps_stride: got lane44=%h stride=%0d required 010c/2", lane(4,4), out_stride); end
        tick();
        do_cfg(1);
        n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL good_cfg_clears_err: got %b required 0", cfg_err); end
        do_cfg(2);
    endtask

    task automatic test_backpressure();
        logic [PE_W-1:0] snap;
        int pops0;
        pops0 = n_pops;
        out_ready = 1'b0; in_valid = 1'b1; in_rows = build_rows(16'h200);
        tick();
        snap = out_pe;
        for (int i = 0; i < 4; i++) begin
            in_rows = build_rows(DW'(16'h300 + i*16'h20));
            #1;
            n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_err++; $display("FAIL stall_ready: got in_ready=%b out_valid=%b required 0/1", in_ready, out_valid); end
            tick();
            n_vec++; if (out_pe !== snap) begin n_err++; $display("FAIL stall_hold: got %h required %h", out_pe, snap); end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_rows = build_rows(DW'(16'h400 + i*16'h20));
            #1;
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b required 1", in_ready); end
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        n_vec++; if (n_pops - pops0 !== 7 || sb.size() != 0) begin n_err++; $display("FAIL b2b_count: got %0d beats out, %0d queued required 7/0", n_pops - pops0, sb.size()); end
    endtask

    task automatic test_cfg_stall();
        out_ready = 1'b0; in_valid = 1'b1; in_rows = build_rows(16'h500);
        tick();
        in_valid = 1'b0; cfg_valid = 1'b1; cfg_stride = SW'(1);
        #1;
        n_vec++; if (cfg_ready !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL cfg_stall_ready: got cfg_ready=%b in_ready=%b required 0/0", cfg_ready, in_ready); end
        tick();
        in_valid = 1'b1; in_rows = build_rows(16'h600); out_ready = 1'b1;
        #1;
        n_vec++; if (out_stride !== SW'(2) || in_ready !== 1'b0) begin n_err++; $display("FAIL cfg_stall_drain: got stride=%0d in_ready=%b required 2/0", out_stride, in_ready); end
        tick();
        n_vec++; if (out_valid !== 1'b0 || cfg_ready !== 1'b1) begin n_err++; $display("FAIL cfg_stall_empty: got out_valid=%b cfg_ready=%b required 0/1", out_valid, cfg_ready); end
        tick();
        cfg_valid = 1'b0;
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_stride !== SW'(1) || lane(4,4) !== 16'h608) begin n_err++; $display("FAIL cfg_stall_new: got stride=%0d lane44=%h required 1/0608", out_stride, lane(4,4)); end
        tick();
    endtask

    task automatic test_async_reset();
        do_cfg(2);
        out_ready = 1'b0; in_valid = 1'b1; in_rows = build_rows(16'h700);
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        sb.delete();
        m_stride = 1;
        m_beats  = 0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || out_pe !== '0 || out_stride !== SW'(1) || cfg_err !== 1'b0) begin n_err++; $display("FAIL async_rst: got valid=%b stride=%0d err=%b pe=%h required 0/1/0/0", out_valid, out_stride, cfg_err, out_pe); end
`ifdef ROW_MAPPER_STATS_EN
        n_vec++; if (beat_cnt !== 32'd0) begin n_err++; $display("FAIL async_rst_cnt: got %0d required 0", beat_cnt); end
`endif
        #3;
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_rows = build_rows(DW'(16'h800 + i*16'h20));
            tick();
            n_vec++; if (out_stride !== SW'(1) || lane(4,4) !== DW'(16'h808 + i*16'h20)) begin n_err++; $display("FAIL post_rst_beat: got stride=%0d lane44=%h required 1/%h", out_stride, lane(4,4), DW'(16'h808 + i*16'h20)); end
        end
        in_valid = 1'b0;
`ifdef ROW_MAPPER_STATS_EN
        n_vec++; if (beat_cnt !== 32'(m_beats) || m_beats != 3) begin n_err++; $display("FAIL post_rst_cnt: got %0d required 3", beat_cnt); end
`endif
        tick();
        tick();
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d queued required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_default_stride();
        test_stride2();
        test_illegal_cfg();
        test_backpressure();
        test_cfg_stall();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
